// File: rtl/vga_text_pkg.sv
// Shared geometry, control codes, FSM/cursor enums and the Avalon write payload
// for the VGA text console master.
package vga_text_pkg;

    localparam int unsigned COLS          = 80;
    localparam int unsigned ROWS          = 30;
    localparam int unsigned WORDS_PER_ROW = 20;
    localparam int unsigned CTRL_REG      = 600;
    localparam int unsigned NUM_REGS      = 601;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned CHAR_W  = 8;
    localparam int unsigned COLOR_W = 24;

    localparam logic [6:0] CC_BS = 7'h08;
    localparam logic [6:0] CC_LF = 7'h0A;
    localparam logic [6:0] CC_FF = 7'h0C;
    localparam logic [6:0] CC_CR = 7'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLR_ROW,
        ST_CLR_ALL,
        ST_COLOR
    } state_e;

    typedef enum logic [2:0] {
        CUR_NONE,
        CUR_ADV,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME
    } cur_op_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } avm_wr_t;

    // First VRAM word of a text row.
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        return ADDR_W'(row) * ADDR_W'(WORDS_PER_ROW);
    endfunction

endpackage

// File: rtl/vga_text_cursor.sv
// Cursor column/row counters with column and row wrap, plus the VRAM word
// address and byte lane of the current cell.
module vga_text_cursor
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  cur_op_e           op_i,
    output logic [COL_W-1:0]  col_o,
    output logic [ROW_W-1:0]  row_o,
    output logic [ADDR_W-1:0] word_addr_c,
    output logic [BE_W-1:0]   lane_be_c,
    output logic              last_col_c,
    output logic [ADDR_W-1:0] next_row_base_c
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] row_inc;

    // No scrolling: the row after the last one is row 0.
    assign row_inc         = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    assign last_col_c      = (col_q == COL_W'(COLS - 1));
    assign word_addr_c     = row_base(row_q) + ADDR_W'(col_q[6:2]);
    assign lane_be_c       = BE_W'(4'b0001 << col_q[1:0]);
    assign next_row_base_c = row_base(row_inc);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        case (op_i)
            CUR_ADV: begin
                if (last_col_c) begin
                    col_d = '0;
                    row_d = row_inc;
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            CUR_CR:   col_d = '0;
            CUR_LF: begin
                col_d = '0;
                row_d = row_inc;
            end
            CUR_BS: begin
                if (col_q != '0) col_d = col_q - COL_W'(1);
            end
            CUR_HOME: begin
                col_d = '0;
                row_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/vga_text_console_master.sv
// Turns a character stream and colour updates into Avalon-MM writes to the
// VGA text slave (VRAM words 0-599, control register 600).
module vga_text_console_master
    import vga_text_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               CHAR_VALID,
    input  logic [CHAR_W-1:0]  CHAR_DATA,
    output logic               CHAR_READY,
    input  logic               COLOR_VALID,
    input  logic [COLOR_W-1:0] COLOR_DATA,
    output logic               COLOR_READY,
    output logic               AVM_CS,
    output logic               AVM_WRITE,
    output logic [ADDR_W-1:0]  AVM_ADDR,
    output logic [BE_W-1:0]    AVM_BYTE_EN,
    output logic [DATA_W-1:0]  AVM_WRITEDATA,
    input  logic               AVM_WAITREQUEST,
    output logic [COL_W-1:0]   CURSOR_COL,
    output logic [ROW_W-1:0]   CURSOR_ROW,
    output logic               BUSY
);

    state_e            state_q, state_d;
    avm_wr_t           wr_q, wr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] clr_last_q, clr_last_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    cur_op_e           cur_op;
    logic [ADDR_W-1:0] cur_word_addr;
    logic [BE_W-1:0]   cur_lane_be;
    logic              cur_last_col;
    logic [ADDR_W-1:0] cur_next_row_base;
    logic              wr_done;
    logic [6:0]        code;

    vga_text_cursor u_cursor (
        .clk             (CLK),
        .rst_n           (RESET_N),
        .op_i            (cur_op),
        .col_o           (CURSOR_COL),
        .row_o           (CURSOR_ROW),
        .word_addr_c     (cur_word_addr),
        .lane_be_c       (cur_lane_be),
        .last_col_c      (cur_last_col),
        .next_row_base_c (cur_next_row_base)
    );

    assign wr_done = wr_en_q && !AVM_WAITREQUEST;
    assign code    = CHAR_DATA[6:0];

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        wr_en_d    = wr_en_q;
        clr_cnt_d  = clr_cnt_q;
        clr_last_d = clr_last_q;
        cur_op     = CUR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (ready_q && COLOR_VALID) begin
                    state_d    = ST_COLOR;
                    wr_en_d    = 1'b1;
                    wr_d.addr  = ADDR_W'(CTRL_REG);
                    wr_d.be    = '1;
                    wr_d.data  = {7'b0, COLOR_DATA, 1'b0};
                end else if (ready_q && CHAR_VALID) begin
                    case (code)
                        CC_CR: begin
                            cur_op  = CUR_CR;
                            state_d = ST_PUT;
                        end
                        CC_BS: begin
                            cur_op  = CUR_BS;
                            state_d = ST_PUT;
                        end
                        CC_LF: begin
                            cur_op     = CUR_LF;
                            state_d    = ST_CLR_ROW;
                            wr_en_d    = 1'b1;
                            wr_d.addr  = cur_next_row_base;
                            wr_d.be    = '1;
                            wr_d.data  = '0;
                            clr_cnt_d  = '0;
                            clr_last_d = ADDR_W'(WORDS_PER_ROW - 1);
                        end
                        CC_FF: begin
                            state_d    = ST_CLR_ALL;
                            wr_en_d    = 1'b1;
                            wr_d.addr  = '0;
                            wr_d.be    = '1;
                            wr_d.data  = '0;
                            clr_cnt_d  = '0;
                            clr_last_d = ADDR_W'(CTRL_REG - 1);
                        end
                        default: begin
                            state_d   = ST_PUT;
                            wr_en_d   = 1'b1;
                            wr_d.addr = cur_word_addr;
                            wr_d.be   = cur_lane_be;
                            wr_d.data = {4{CHAR_DATA}};
                        end
                    endcase
                end
            end

            // CR/BS pass through here for one cycle without a bus write.
            ST_PUT: begin
                if (!wr_en_q) begin
                    state_d = ST_IDLE;
                end else if (wr_done) begin
                    wr_en_d = 1'b0;
                    cur_op  = CUR_ADV;
                    state_d = ST_IDLE;
                    if (cur_last_col) begin
                        state_d    = ST_CLR_ROW;
                        wr_en_d    = 1'b1;
                        wr_d.addr  = cur_next_row_base;
                        wr_d.be    = '1;
                        wr_d.data  = '0;
                        clr_cnt_d  = '0;
                        clr_last_d = ADDR_W'(WORDS_PER_ROW - 1);
                    end
                end
            end

            ST_CLR_ROW, ST_CLR_ALL: begin
                if (wr_done) begin
                    if (clr_cnt_q == clr_last_q) begin
                        wr_en_d = 1'b0;
                        state_d = ST_IDLE;
                        if (state_q == ST_CLR_ALL) cur_op = CUR_HOME;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                        wr_d.addr = wr_q.addr + ADDR_W'(1);
                    end
                end
            end

            ST_COLOR: begin
                if (wr_done) begin
                    wr_en_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            wr_q       <= '0;
            wr_en_q    <= 1'b0;
            clr_cnt_q  <= '0;
            clr_last_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            wr_en_q    <= wr_en_d;
            clr_cnt_q  <= clr_cnt_d;
            clr_last_q <= clr_last_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // Colour has priority, so the character handshake is masked by COLOR_VALID.
    assign COLOR_READY   = ready_q;
    assign CHAR_READY    = ready_q && !COLOR_VALID;
    assign AVM_CS        = wr_en_q;
    assign AVM_WRITE     = wr_en_q;
    assign AVM_ADDR      = wr_q.addr;
    assign AVM_BYTE_EN   = wr_q.be;
    assign AVM_WRITEDATA = wr_q.data;
    assign BUSY          = busy_q;

endmodule
